// File: rtl/counter_pkg.sv
// Shared helpers for the modulo-N digit counters: digit sizing and the
// widest digit type any supported radix (2..16) can need.
package counter_pkg;

    localparam int MAX_MODULUS = 16;
    localparam int MIN_MODULUS = 2;

    // Bits needed to hold digit values 0..modulus-1.
    function automatic int digit_width(input int modulus);
        return (modulus <= 2) ? 1 : $clog2(modulus);
    endfunction

    // Largest value a digit of the given radix may hold.
    function automatic int max_digit(input int modulus);
        return modulus - 1;
    endfunction

    localparam int MAX_DW = digit_width(MAX_MODULUS);

    typedef logic [MAX_DW-1:0] digit_t;

endpackage

// File: rtl/mod_n_digit.sv
// One modulo-N up/down digit with synchronous load (saturating) and a
// terminal-count output that doubles as the enable for the next digit.
module mod_n_digit
    import counter_pkg::*;
#(
    parameter int MODULUS = 10,
    parameter int DW      = digit_width(MODULUS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          up,
    input  logic          load,
    input  logic [DW-1:0] ld_val,
    output logic [DW-1:0] q,
    output logic          tc_out
);

    localparam logic [DW-1:0] MAX_VAL = DW'(max_digit(MODULUS));
    localparam logic [DW:0]   MOD_VAL = (DW+1)'(MODULUS);

    logic [DW-1:0] r_q;
    logic [DW-1:0] w_ld_sat;

    // Out-of-range load values clamp to the largest legal digit.
    assign w_ld_sat = ({1'b0, ld_val} >= MOD_VAL) ? MAX_VAL : ld_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= w_ld_sat;
        end else if (en) begin
            if (up) begin
                r_q <= (r_q == MAX_VAL) ? '0 : r_q + 1'b1;
            end else begin
                r_q <= (r_q == '0) ? MAX_VAL : r_q - 1'b1;
            end
        end
    end

    assign q      = r_q;
    assign tc_out = en & (up ? (r_q == MAX_VAL) : (r_q == '0));

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit modulo-N up/down counter built from a ripple-enable chain of
// digits; tc cascades to a following counter, wrap flags a full-range roll.
module bcd_updown_counter
    import counter_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int MODULUS = 10
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   enable,
    input  logic                                   up,
    input  logic                                   load,
    input  logic [DIGITS*digit_width(MODULUS)-1:0] load_value,
    output logic [DIGITS*digit_width(MODULUS)-1:0] count,
    output logic                                   tc,
    output logic                                   wrap
);

    localparam int DW = digit_width(MODULUS);

    logic [DIGITS-1:0] w_tc_chain;
    logic [DIGITS-1:0] w_digit_en;
    logic              r_wrap;

    // Digit k advances only when every lower digit sits at its terminal
    // value, which is exactly the previous digit's tc_out.
    assign w_digit_en[0] = enable;

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_digit
            if (k > 0) begin : g_chain
                assign w_digit_en[k] = w_tc_chain[k-1];
            end
            mod_n_digit #(
                .MODULUS(MODULUS),
                .DW     (DW)
            ) u_digit (
                .clk   (clk),
                .reset (reset),
                .en    (w_digit_en[k]),
                .up    (up),
                .load  (load),
                .ld_val(load_value[k*DW +: DW]),
                .q     (count[k*DW +: DW]),
                .tc_out(w_tc_chain[k])
            );
        end
    endgenerate

    assign tc = w_tc_chain[DIGITS-1];

    // wrap lines up with the wrapped count value, one edge after tc.
    always_ff @(posedge clk) begin
        if (reset || load) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= tc;
        end
    end

    assign wrap = r_wrap;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for a 2-digit decimal bcd_updown_counter.
`timescale 1ns/100ps
module tb_bcd_updown_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       up;
  logic       load;
  logic [7:0] load_value;
  logic [7:0] count;
  logic       tc;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  // clock / reset block
  always #7.5 clk = ~clk;

  bcd_updown_counter #(
    .DIGITS (2),
    .MODULUS(10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .up        (up),
    .load      (load),
    .load_value(load_value),
    .count     (count),
    .tc        (tc),
    .wrap      (wrap)
  );

  // scoreboard
  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver: advance one edge, settle 1 ns past it
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [7:0] up_seq [12];

  initial begin
    up_seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
               8'h07, 8'h08, 8'h09, 8'h10, 8'h11, 8'h12};
    reset = 1'b1; enable = 1'b1; up = 1'b1; load = 1'b0; load_value = 8'h00;

    // 1. reset
    step(2);
    check_val("rst_count", count, 8'h00);
    check_val("rst_wrap", {7'b0, wrap}, 8'h00);
    check_val("rst_tc", {7'b0, tc}, 8'h00);
    reset = 1'b0;
    step(1);
    check_val("post_rst", count, 8'h01);

    // 2. count up through a digit carry
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      check_val("up_seq", count, up_seq[i]);
      check_val("up_seq_wrap", {7'b0, wrap}, 8'h00);
    end

    // 3. load 98 and wrap upward
    load = 1'b1; load_value = 8'h98;
    step(1);
    check_val("ld98", count, 8'h98);
    check_val("ld98_wrap", {7'b0, wrap}, 8'h00);
    load = 1'b0;
    #1 check_val("tc_98", {7'b0, tc}, 8'h00);
    step(1);
    check_val("up99", count, 8'h99);
    check_val("tc_99", {7'b0, tc}, 8'h01);
    step(1);
    check_val("wrap_00", count, 8'h00);
    check_val("wrap_hi", {7'b0, wrap}, 8'h01);
    check_val("tc_00_up", {7'b0, tc}, 8'h00);
    step(1);
    check_val("after_wrap", count, 8'h01);
    check_val("wrap_lo", {7'b0, wrap}, 8'h00);

    // 4. count down through wrap, then flip direction
    load = 1'b1; load_value = 8'h01; up = 1'b0;
    step(1);
    check_val("ld01", count, 8'h01);
    load = 1'b0;
    #1 check_val("tc_01_dn", {7'b0, tc}, 8'h00);
    step(1);
    check_val("dn00", count, 8'h00);
    check_val("tc_00_dn", {7'b0, tc}, 8'h01);
    step(1);
    check_val("dn99", count, 8'h99);
    check_val("dn_wrap_hi", {7'b0, wrap}, 8'h01);
    step(1);
    check_val("dn98", count, 8'h98);
    check_val("dn_wrap_lo", {7'b0, wrap}, 8'h00);
    up = 1'b1;
    step(1);
    check_val("flip99", count, 8'h99);

    // 5. enable windows and saturating load
    enable = 1'b0;
    #1 check_val("tc_dis", {7'b0, tc}, 8'h00);
    step(3);
    check_val("hold99", count, 8'h99);
    check_val("hold_wrap", {7'b0, wrap}, 8'h00);
    enable = 1'b1;
    step(1);
    check_val("en_00", count, 8'h00);
    check_val("en_wrap", {7'b0, wrap}, 8'h01);
    step(12);
    check_val("en_12", count, 8'h12);
    enable = 1'b0;
    step(3);
    check_val("hold12", count, 8'h12);
    check_val("tc_dis2", {7'b0, tc}, 8'h00);
    load = 1'b1; load_value = 8'hAF;
    step(1);
    check_val("sat_AF", count, 8'h99);
    load_value = 8'h3C;
    step(1);
    check_val("sat_3C", count, 8'h39);
    load = 1'b0;

    // 6. reset wins over load, and clears a pending wrap
    enable = 1'b1; load = 1'b1; load_value = 8'h57;
    step(1);
    check_val("ld57", count, 8'h57);
    reset = 1'b1; load_value = 8'h44;
    step(1);
    check_val("rst_ld", count, 8'h00);
    check_val("rst_ld_wrap", {7'b0, wrap}, 8'h00);
    reset = 1'b0; load_value = 8'h99;
    step(1);
    load = 1'b0;
    #1 check_val("tc_pre_rst", {7'b0, tc}, 8'h01);
    reset = 1'b1;
    step(1);
    check_val("rst_tc_count", count, 8'h00);
    check_val("rst_tc_wrap", {7'b0, wrap}, 8'h00);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
